// File: rtl/ime_sad_sched.sv
// IME SAD sequencer: walks the (2*SR)^2 integer candidates of a search window in raster order.
// It issues one candidate per accepted cycle and returns MV/last tags aligned to the merged SAD outputs.
// Latency: cand_v_o is registered one cycle after the accepting edge. sad4x4_v_o follows PIPE_LAT cycles after it, and sad_v_o PIPE_LAT+1 cycles after it.
// Backpressure: ref_rdy_i=0 stalls issue only. The delay line keeps shifting, so bubbles propagate to the merge stage.
//
// Ports:
//   clk, rstn               clock, synchronous active-low reset
//   start_i                 single-cycle start, honoured only in IDLE
//   ref_rdy_i               reference fetch accepts a candidate this cycle
//   busy_o                  search in progress (ISSUE or DRAIN)
//   cand_v_o/_mvx_o/_mvy_o  registered candidate strobe and signed MV
//   sad4x4_v_o              valid into the merge stage (delay line tail)
//   sad_v_o/_mvx_o/_mvy_o   merged-SAD valid with aligned MV (MV holds when idle)
//   sad_last_o, done_o      aligned last flag and one-cycle completion pulse
module ime_sad_sched #(
    parameter int SR       = 16,
    parameter int PIPE_LAT = 4,
    parameter int MV_LEN   = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              ref_rdy_i,
    output logic              busy_o,
    output logic              cand_v_o,
    output logic [MV_LEN-1:0] cand_mvx_o,
    output logic [MV_LEN-1:0] cand_mvy_o,
    output logic              sad4x4_v_o,
    output logic              sad_v_o,
    output logic [MV_LEN-1:0] sad_mvx_o,
    output logic [MV_LEN-1:0] sad_mvy_o,
    output logic              sad_last_o,
    output logic              done_o
);

    localparam int                CW      = $clog2(2 * SR);
    localparam logic [CW-1:0]     CNT_MAX = CW'(2 * SR - 1);
    localparam logic [MV_LEN-1:0] SR_MV   = MV_LEN'(SR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_nxt;

    logic [CW-1:0]     x_cnt, y_cnt;
    logic              load;
    logic              issue;
    logic              issue_last;
    logic              cand_last_q;
    logic [MV_LEN-1:0] mvx_nxt, mvy_nxt;

    // Delay line toward the merge stage: {valid, last, mvx, mvy} per stage.
    logic [PIPE_LAT-1:0] dl_v;
    logic [PIPE_LAT-1:0] dl_last;
    logic [MV_LEN-1:0]   dl_mvx [PIPE_LAT];
    logic [MV_LEN-1:0]   dl_mvy [PIPE_LAT];

    assign issue_last = (x_cnt == CNT_MAX) && (y_cnt == CNT_MAX);

    // The counters run 0..2*SR-1. Subtracting SR modulo 2^MV_LEN gives the signed offset -SR..SR-1.
    assign mvx_nxt = MV_LEN'(x_cnt) - SR_MV;
    assign mvy_nxt = MV_LEN'(y_cnt) - SR_MV;

    // ------------------------------------------------------------------
    // FSM: next state and decoded controls
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        busy_o    = 1'b0;
        load      = 1'b0;
        issue     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy_o = 1'b1;
                if (ref_rdy_i) begin
                    issue = 1'b1;
                    if (issue_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                // done_o is the final aligned result; all tagged results have left by then.
                if (done_o) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Position counters and registered issue outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            cand_v_o    <= 1'b0;
            cand_last_q <= 1'b0;
            cand_mvx_o  <= '0;
            cand_mvy_o  <= '0;
        end else begin
            cand_v_o    <= issue;
            cand_last_q <= issue & issue_last;
            if (load) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (issue) begin
                cand_mvx_o <= mvx_nxt;
                cand_mvy_o <= mvy_nxt;
                if (x_cnt == CNT_MAX) begin
                    x_cnt <= '0;
                    y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Delay line: shifts every cycle, including stall bubbles
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dl_v    <= '0;
            dl_last <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_mvx[i] <= '0;
                dl_mvy[i] <= '0;
            end
        end else begin
            dl_v[0]    <= cand_v_o;
            dl_last[0] <= cand_last_q;
            dl_mvx[0]  <= cand_mvx_o;
            dl_mvy[0]  <= cand_mvy_o;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_v[i]    <= dl_v[i-1];
                dl_last[i] <= dl_last[i-1];
                dl_mvx[i]  <= dl_mvx[i-1];
                dl_mvy[i]  <= dl_mvy[i-1];
            end
        end
    end

    assign sad4x4_v_o = dl_v[PIPE_LAT-1];

    // ------------------------------------------------------------------
    // Output stage: mirrors the merge stage's output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sad_v_o    <= 1'b0;
            sad_last_o <= 1'b0;
            sad_mvx_o  <= '0;
            sad_mvy_o  <= '0;
        end else begin
            sad_v_o    <= dl_v[PIPE_LAT-1];
            sad_last_o <= dl_v[PIPE_LAT-1] & dl_last[PIPE_LAT-1];
            // The MV outputs hold through bubbles so downstream logic can sample them lazily.
            if (dl_v[PIPE_LAT-1]) begin
                sad_mvx_o <= dl_mvx[PIPE_LAT-1];
                sad_mvy_o <= dl_mvy[PIPE_LAT-1];
            end
        end
    end

    assign done_o = sad_v_o & sad_last_o;

endmodule

// File: tb/tb_ime_sad_sched.sv
module tb_ime_sad_sched;

    localparam int SR = 2;
    localparam int PL = 3;
    localparam int ML = 7;
    localparam int NC = 4 * SR * SR;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_i = 1'b0;
    logic ref_rdy_i = 1'b1;

    logic          busy_o, cand_v_o, sad4x4_v_o, sad_v_o, sad_last_o, done_o;
    logic [ML-1:0] cand_mvx_o, cand_mvy_o, sad_mvx_o, sad_mvy_o;

    logic          start_b = 1'b0;
    logic          rdy_b = 1'b1;
    logic          b_busy, b_cand_v, b_s4_v, b_sad_v, b_last, b_done;
    logic [ML-1:0] b_cmvx, b_cmvy, b_smvx, b_smvy;

    ime_sad_sched #(.SR(SR), .PIPE_LAT(PL), .MV_LEN(ML)) u_dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .ref_rdy_i(ref_rdy_i),
        .busy_o(busy_o), .cand_v_o(cand_v_o), .cand_mvx_o(cand_mvx_o), .cand_mvy_o(cand_mvy_o),
        .sad4x4_v_o(sad4x4_v_o), .sad_v_o(sad_v_o), .sad_mvx_o(sad_mvx_o), .sad_mvy_o(sad_mvy_o),
        .sad_last_o(sad_last_o), .done_o(done_o)
    );

    ime_sad_sched #(.SR(16), .PIPE_LAT(4), .MV_LEN(ML)) u_big (
        .clk(clk), .rstn(rstn), .start_i(start_b), .ref_rdy_i(rdy_b),
        .busy_o(b_busy), .cand_v_o(b_cand_v), .cand_mvx_o(b_cmvx), .cand_mvy_o(b_cmvy),
        .sad4x4_v_o(b_s4_v), .sad_v_o(b_sad_v), .sad_mvx_o(b_smvx), .sad_mvy_o(b_smvy),
        .sad_last_o(b_last), .done_o(b_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    logic rst_edge = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !rstn;
    end

    typedef struct {
        int          cyc;
        logic [ML-1:0] mvx;
        logic [ML-1:0] mvy;
        logic        last;
    } exp_t;

    exp_t q_cand[$];
    exp_t q_s4[$];
    exp_t q_sad[$];
    int   q_done[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input bit ok, input string nm, input int act, input int exp);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void chk_mv(input bit ok, input string nm,
                                   input logic [ML-1:0] ax, input logic [ML-1:0] ay,
                                   input logic [ML-1:0] ex, input logic [ML-1:0] ey);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got (%0d,%0d), required (%0d,%0d) (cycle %0d)", nm,
                     $signed(ax), $signed(ay), $signed(ex), $signed(ey), cyc);
        end
    endfunction

    function automatic int any_out();
        return int'(busy_o) + int'(cand_v_o) + int'(sad4x4_v_o) + int'(sad_v_o) +
               int'(sad_last_o) + int'(done_o) + int'(|cand_mvx_o) + int'(|cand_mvy_o) +
               int'(|sad_mvx_o) + int'(|sad_mvy_o);
    endfunction

    // Expected results for one search started at edge t0.
    // Offsets s0/s1 are edges (relative to t0) where ref_rdy_i is low.
    // Only entries due before edge lim are queued.
    function automatic void push_search(input int t0, input int s0, input int s1, input int lim);
        int   e;
        exp_t x;
        e = t0;
        for (int k = 0; k < NC; k++) begin
            e++;
            while ((e - t0) == s0 || (e - t0) == s1) e++;
            x.mvx  = ML'((k % (2 * SR)) - SR);
            x.mvy  = ML'((k / (2 * SR)) - SR);
            x.last = (k == NC - 1);
            x.cyc  = e;
            if (x.cyc < lim) q_cand.push_back(x);
            x.cyc = e + PL;
            if (x.cyc < lim) q_s4.push_back(x);
            x.cyc = e + PL + 1;
            if (x.cyc < lim) begin
                q_sad.push_back(x);
                if (x.last) q_done.push_back(x.cyc);
            end
        end
    endfunction

    // Monitor for the small instance: pops expectations whenever the DUT presents an output.
    logic [ML-1:0] hx = '0;
    logic [ML-1:0] hy = '0;
    always @(negedge clk) begin : mon
        exp_t e;
        int   d;
        if (rst_edge) begin
            hx = '0;
            hy = '0;
        end
        if (cand_v_o) begin
            if (q_cand.size() == 0) chk(1'b0, "cand_unexpected", cyc, -1);
            else begin
                e = q_cand.pop_front();
                chk(cyc == e.cyc, "cand_cycle", cyc, e.cyc);
                chk_mv(cand_mvx_o == e.mvx && cand_mvy_o == e.mvy, "cand_mv",
                       cand_mvx_o, cand_mvy_o, e.mvx, e.mvy);
            end
        end
        if (sad4x4_v_o) begin
            if (q_s4.size() == 0) chk(1'b0, "sad4x4_unexpected", cyc, -1);
            else begin
                e = q_s4.pop_front();
                chk(cyc == e.cyc, "sad4x4_cycle", cyc, e.cyc);
            end
        end
        if (sad_v_o) begin
            if (q_sad.size() == 0) chk(1'b0, "sad_unexpected", cyc, -1);
            else begin
                e = q_sad.pop_front();
                chk(cyc == e.cyc, "sad_cycle", cyc, e.cyc);
                chk_mv(sad_mvx_o == e.mvx && sad_mvy_o == e.mvy, "sad_mv",
                       sad_mvx_o, sad_mvy_o, e.mvx, e.mvy);
                chk(sad_last_o == e.last, "sad_last", int'(sad_last_o), int'(e.last));
                hx = e.mvx;
                hy = e.mvy;
            end
        end else begin
            chk_mv(sad_mvx_o == hx && sad_mvy_o == hy, "sad_mv_hold", sad_mvx_o, sad_mvy_o, hx, hy);
        end
        if (done_o) begin
            if (q_done.size() == 0) chk(1'b0, "done_unexpected", cyc, -1);
            else begin
                d = q_done.pop_front();
                chk(cyc == d, "done_cycle", cyc, d);
            end
        end
    end

    // Monitor for the default-size instance: row wrap and corner candidates.
    int bk = 0;
    int bs = 0;
    int bd = 0;
    always @(negedge clk) begin : mon_big
        logic [ML-1:0] ex, ey;
        if (b_cand_v) begin
            ex = ML'((bk % 32) - 16);
            ey = ML'((bk / 32) - 16);
            chk_mv(b_cmvx == ex && b_cmvy == ey, "big_cand_mv", b_cmvx, b_cmvy, ex, ey);
            if (bk == 31) chk_mv(b_cmvx == 7'd15 && b_cmvy == 7'h70, "big_row_end", b_cmvx, b_cmvy, 7'd15, 7'h70);
            if (bk == 32) chk_mv(b_cmvx == 7'h70 && b_cmvy == 7'h71, "big_wrap", b_cmvx, b_cmvy, 7'h70, 7'h71);
            if (bk == 1023) chk_mv(b_cmvx == 7'd15 && b_cmvy == 7'd15, "big_last", b_cmvx, b_cmvy, 7'd15, 7'd15);
            bk++;
        end
        if (b_sad_v) bs++;
        if (b_done) bd++;
    end

    function automatic void chk_drained(input string nm);
        int n;
        n = q_cand.size() + q_s4.size() + q_sad.size() + q_done.size();
        chk(n == 0, nm, n, 0);
    endfunction

    // Called at a negedge. Starts a search with stalls at edges t0+s0/t0+s1 and an extra start at t0+xs.
    // doff is the hand-computed done edge offset.
    task automatic run(input int s0, input int s1, input int xs, input int doff);
        int t0;
        t0 = cyc + 1;
        start_i = 1'b1;
        push_search(t0, s0, s1, 1 << 30);
        for (int r = 0; r <= doff + 1; r++) begin
            @(negedge clk);
            start_i   = (r + 1 == xs);
            ref_rdy_i = !((r + 1) == s0 || (r + 1) == s1);
            if (r == 0) chk(busy_o === 1'b1, "busy_after_start", int'(busy_o), 1);
            if (r == doff) chk(done_o === 1'b1 && busy_o === 1'b1, "done_at_offset",
                               int'(done_o) * 2 + int'(busy_o), 3);
            if (r == doff + 1) chk(done_o === 1'b0 && busy_o === 1'b0, "idle_after_done",
                                   int'(done_o) * 2 + int'(busy_o), 0);
        end
        ref_rdy_i = 1'b1;
        start_i   = 1'b0;
        chk_drained("queues_drained");
    endtask

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk(any_out() == 0, "reset_state", any_out(), 0);
        chk(b_busy === 1'b0 && b_cand_v === 1'b0 && b_sad_v === 1'b0, "reset_state_big",
            int'(b_busy) + int'(b_cand_v) + int'(b_sad_v), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Plain search, then a back-to-back search from the first IDLE cycle.
        run(-1, -1, -1, 20);
        run(-1, -1, -1, 20);

        // Two stalled issue cycles: done slips by two.
        @(negedge clk);
        run(3, 4, -1, 22);

        // Start pulsed mid-search: ignored.
        @(negedge clk);
        run(-1, -1, 6, 20);

        // Reset at edge t0+9 with a coincident start: abort, no done, stay idle.
        @(negedge clk);
        t0 = cyc + 1;
        start_i = 1'b1;
        push_search(t0, -1, -1, t0 + 9);
        for (int r = 0; r <= 20; r++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (r == 8) begin
                rstn    = 1'b0;
                start_i = 1'b1;
            end
            if (r == 9) begin
                rstn = 1'b1;
                chk(any_out() == 0, "abort_outputs_zero", any_out(), 0);
            end
            if (r == 10) chk(busy_o === 1'b0, "abort_stays_idle", int'(busy_o), 0);
        end
        chk_drained("abort_drained");

        // A fresh start restarts from (-2,-2).
        @(negedge clk);
        run(-1, -1, -1, 20);

        // Full default-size window.
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!b_busy) break;
        end
        chk(b_busy === 1'b0, "big_timeout", int'(b_busy), 0);
        chk(bk == 1024, "big_cand_count", bk, 1024);
        chk(bs == 1024, "big_sad_count", bs, 1024);
        chk(bd == 1, "big_done_count", bd, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
